jtframe_rom_arb: RTL and testbench

JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

---
 rtl/jtframe_rom_arb.sv | 137 +++++++++++++
 tb/tb_jtframe_rom_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_arb.sv
// ROM slot arbiter: every game ROM slot owns a one-entry read cache. Misses share
// one SDRAM port through a fixed-priority or round-robin arbiter, one fill at a time.
module jtframe_rom_arb #(
   parameter int CH = 4,
   parameter int AW = 22,
   parameter int DW = 32,
   parameter bit RR = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             downloading,
   input  logic             loop_rst,
   input  logic [CH*AW-1:0] slot_addr,
   input  logic [CH-1:0]    slot_req,
   output logic [CH-1:0]    slot_ok,
   output logic [CH*DW-1:0] slot_dout,
   output logic [AW-1:0]    sdram_addr,
   output logic             sdram_req,
   input  logic             sdram_ack,
   input  logic [DW-1:0]    data_read,
   input  logic             data_rdy,
   output logic             refresh_en
);
   localparam int GW = (CH > 1) ? $clog2(CH) : 1;

   // SDRAM side handshake: sdram_req is held with a constant sdram_addr until the
   // one-cycle sdram_ack; data_rdy is a one-cycle strobe that may coincide with the ack.
   typedef enum logic [1:0] { IDLE, WAIT_ACK, WAIT_RDY } state_t;

   state_t        state_q;
   logic [AW-1:0] tag_q  [CH];
   logic [DW-1:0] data_q [CH];
   logic [CH-1:0] valid_q;
   logic [GW-1:0] gnt_q;
   logic [GW-1:0] last_q;
   logic [GW-1:0] gnt_d;
   logic [AW-1:0] addr_q;
   logic          req_q;
   logic          stale_q;
   logic [CH-1:0] pending;
   logic          found_d;
   logic          fill;
   int            pos;

   for (genvar i = 0; i < CH; i++) begin : g_slot
      assign slot_ok[i] = slot_req[i] & valid_q[i] & (tag_q[i] == slot_addr[i*AW +: AW]);
      assign slot_dout[i*DW +: DW] = data_q[i];
   end

   assign pending    = slot_req & ~slot_ok;
   assign sdram_addr = addr_q;
   assign sdram_req  = req_q;
   assign refresh_en = !rst_n || downloading || (state_q == IDLE && pending == '0);

   // A fetch that overlapped a download is completed on the bus but never cached.
   assign fill = data_rdy && !downloading && !stale_q &&
                 ((state_q == WAIT_RDY) || (state_q == WAIT_ACK && sdram_ack));

   always_comb begin
      gnt_d   = '0;
      found_d = 1'b0;
      pos     = 0;
      for (int k = 0; k < CH; k++) begin
         pos = RR ? (int'(last_q) + 1 + k) : k;
         if (pos >= CH) pos = pos - CH;
         if (!found_d && pending[pos[GW-1:0]]) begin
            found_d = 1'b1;
            gnt_d   = pos[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= '0;
         gnt_q   <= '0;
         last_q  <= GW'(CH - 1);
         addr_q  <= '0;
         req_q   <= 1'b0;
         stale_q <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else if (loop_rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         gnt_q   <= '0;
         last_q  <= GW'(CH - 1);
         addr_q  <= '0;
         req_q   <= 1'b0;
         stale_q <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (downloading) begin
            valid_q <= '0;
         end else if (fill) begin
            tag_q[gnt_q]   <= addr_q;
            data_q[gnt_q]  <= data_read;
            valid_q[gnt_q] <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (found_d && !downloading) begin
                  gnt_q   <= gnt_d;
                  last_q  <= gnt_d;
                  addr_q  <= slot_addr[gnt_d*AW +: AW];
                  req_q   <= 1'b1;
                  stale_q <= 1'b0;
                  state_q <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (downloading) stale_q <= 1'b1;
               if (sdram_ack) begin
                  req_q   <= 1'b0;
                  state_q <= data_rdy ? IDLE : WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               if (downloading) stale_q <= 1'b1;
               if (data_rdy) state_q <= IDLE;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb: instance 0 uses fixed priority, instance 1 round-robin.
// Issued SDRAM addresses are predicted into exp_q and checked as the arbiter produces them.
module tb_jtframe_rom_arb;
   localparam int CH = 4;
   localparam int AW = 22;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             downloading [2];
   logic             loop_rst    [2];
   logic [CH*AW-1:0] slot_addr   [2];
   logic [CH-1:0]    slot_req    [2];
   logic [CH-1:0]    slot_ok     [2];
   logic [CH*DW-1:0] slot_dout   [2];
   logic [AW-1:0]    sdram_addr  [2];
   logic             sdram_req   [2];
   logic             sdram_ack   [2];
   logic [DW-1:0]    data_read   [2];
   logic             data_rdy    [2];
   logic             refresh_en  [2];

   for (genvar u = 0; u < 2; u++) begin : g_dut
      jtframe_rom_arb #(.CH(CH), .AW(AW), .DW(DW), .RR(u == 1)) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .downloading (downloading[u]),
         .loop_rst    (loop_rst[u]),
         .slot_addr   (slot_addr[u]),
         .slot_req    (slot_req[u]),
         .slot_ok     (slot_ok[u]),
         .slot_dout   (slot_dout[u]),
         .sdram_addr  (sdram_addr[u]),
         .sdram_req   (sdram_req[u]),
         .sdram_ack   (sdram_ack[u]),
         .data_read   (data_read[u]),
         .data_rdy    (data_rdy[u]),
         .refresh_en  (refresh_en[u])
      );
   end

   logic [AW-1:0] exp_q[$];
   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int u, input int s, input logic [AW-1:0] a);
      slot_addr[u][s*AW +: AW] = a;
      slot_req[u][s] = 1'b1;
   endtask

   // Answers one SDRAM request. ack comes ack_dly cycles after sdram_req is first seen;
   // data_rdy comes rdy_dly cycles after the post-ack cycle (0: together with the ack,
   // negative: never). mode 1 drops slot_req[s], mode 2 moves slot s to na, after the ack.
   task automatic serve(input int u, input int ack_dly, input int rdy_dly,
                        input logic [DW-1:0] d, input int mode, input int s,
                        input logic [AW-1:0] na);
      int n;
      logic [AW-1:0] e;
      n = 0;
      while (sdram_req[u] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_issued", 64'(sdram_req[u]), 64'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("req_addr", 64'(sdram_addr[u]), 64'(e));
      for (int i = 1; i <= ack_dly; i++) begin
         tick();
         if (i == ack_dly) begin
            sdram_ack[u] = 1'b1;
            if (rdy_dly == 0) begin
               data_rdy[u]  = 1'b1;
               data_read[u] = d;
            end
         end
         @(negedge clk);
         chk("req_hold", 64'(sdram_req[u]), 64'd1);
         chk("addr_hold", 64'(sdram_addr[u]), 64'(e));
      end
      tick();
      sdram_ack[u] = 1'b0;
      data_rdy[u]  = 1'b0;
      if (mode == 1) slot_req[u][s] = 1'b0;
      else if (mode == 2) slot_addr[u][s*AW +: AW] = na;
      @(negedge clk);
      chk("req_drop", 64'(sdram_req[u]), 64'd0);
      if (rdy_dly > 0) begin
         for (int j = 1; j <= rdy_dly; j++) begin
            tick();
            if (j == rdy_dly) begin
               data_rdy[u]  = 1'b1;
               data_read[u] = d;
            end
            @(negedge clk);
            chk("refresh_busy", 64'(refresh_en[u]), 64'd0);
         end
         tick();
         data_rdy[u]  = 1'b0;
         data_read[u] = $urandom;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         downloading[u] = 1'b0;
         loop_rst[u]    = 1'b0;
         sdram_ack[u]   = 1'b0;
         data_rdy[u]    = 1'b0;
         slot_addr[u]   = '0;
         slot_req[u]    = '0;
         data_read[u]   = $urandom;
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_req", 64'(sdram_req[u]), 64'd0);
         chk("rst_addr", 64'(sdram_addr[u]), 64'd0);
         chk("rst_ok", 64'(slot_ok[u]), 64'd0);
         chk("rst_dout", 64'(slot_dout[u] != '0), 64'd0);
         chk("rst_refresh", 64'(refresh_en[u]), 64'd1);
      end
      rst_n = 1'b1;

      // single miss: slot 1 at 0x00123, ack in cycle 3, data_rdy in cycle 6
      tick();
      set_slot(0, 1, 22'h00123);
      exp_q.push_back(22'h00123);
      @(negedge clk);
      chk("miss_ok_low", 64'(slot_ok[0][1]), 64'd0);
      chk("miss_no_req_yet", 64'(sdram_req[0]), 64'd0);
      chk("miss_refresh", 64'(refresh_en[0]), 64'd0);
      serve(0, 2, 2, 32'hDEADBEEF, 0, 0, '0);
      chk("miss_ok", 64'(slot_ok[0][1]), 64'd1);
      chk("miss_dout", 64'(slot_dout[0][1*DW +: DW]), 64'hDEADBEEF);

      // hit: re-request is ok in the same cycle, no SDRAM traffic
      tick();
      slot_req[0][1] = 1'b0;
      tick();
      slot_req[0][1] = 1'b1;
      #1;
      chk("hit_ok", 64'(slot_ok[0][1]), 64'd1);
      repeat (3) begin
         @(negedge clk);
         chk("hit_no_req", 64'(sdram_req[0]), 64'd0);
      end
      chk("hit_refresh", 64'(refresh_en[0]), 64'd1);
      tick();
      slot_req[0][1] = 1'b0;

      // fixed priority contention: 0, 2, 3
      tick();
      set_slot(0, 0, 22'h00100);
      set_slot(0, 2, 22'h00200);
      set_slot(0, 3, 22'h00300);
      exp_q.push_back(22'h00100);
      exp_q.push_back(22'h00200);
      exp_q.push_back(22'h00300);
      serve(0, 1, 1, 32'h0000_0100, 0, 0, '0);
      chk("fp_ok0", 64'(slot_ok[0]), 64'b0001);
      serve(0, 3, 2, 32'h0000_0200, 0, 0, '0);
      chk("fp_ok2", 64'(slot_ok[0]), 64'b0101);
      serve(0, 1, 3, 32'h0000_0300, 0, 0, '0);
      chk("fp_ok3", 64'(slot_ok[0]), 64'b1101);

      // round robin: grant to 2 first, then contention gives 3, 0, 2
      tick();
      set_slot(1, 2, 22'h00222);
      exp_q.push_back(22'h00222);
      serve(1, 1, 1, 32'h0000_0A22, 0, 0, '0);
      chk("rr_first_ok", 64'(slot_ok[1]), 64'b0100);
      tick();
      set_slot(1, 0, 22'h000A0);
      set_slot(1, 2, 22'h002A0);
      set_slot(1, 3, 22'h003A0);
      exp_q.push_back(22'h003A0);
      exp_q.push_back(22'h000A0);
      exp_q.push_back(22'h002A0);
      serve(1, 1, 1, 32'h0000_03A0, 0, 0, '0);
      serve(1, 2, 1, 32'h0000_00A0, 0, 0, '0);
      serve(1, 1, 2, 32'h0000_02A0, 0, 0, '0);
      chk("rr_all_ok", 64'(slot_ok[1]), 64'b1101);
      chk("rr_dout0", 64'(slot_dout[1][0 +: DW]), 64'h0000_00A0);
      chk("rr_dout3", 64'(slot_dout[1][3*DW +: DW]), 64'h0000_03A0);

      // address moves from 0x10 to 0x20 after ack: fill tagged 0x10, then re-fetch
      tick();
      slot_addr[0][0 +: AW] = 22'h00010;
      exp_q.push_back(22'h00010);
      serve(0, 1, 2, 32'h1111_1111, 2, 0, 22'h00020);
      exp_q.push_back(22'h00020);
      chk("move_ok_low", 64'(slot_ok[0][0]), 64'd0);
      chk("move_dout_old", 64'(slot_dout[0][0 +: DW]), 64'h1111_1111);
      serve(0, 2, 1, 32'h2222_2222, 0, 0, '0);
      chk("move_ok", 64'(slot_ok[0][0]), 64'd1);
      chk("move_dout", 64'(slot_dout[0][0 +: DW]), 64'h2222_2222);

      // download: all valid, pulse downloading, then re-fetch everything
      tick();
      set_slot(0, 1, 22'h00123);
      @(negedge clk);
      chk("dl_all_ok", 64'(slot_ok[0]), 64'hF);
      tick();
      downloading[0] = 1'b1;
      @(negedge clk);
      chk("dl_refresh0", 64'(refresh_en[0]), 64'd1);
      repeat (3) begin
         tick();
         @(negedge clk);
         chk("dl_ok_clear", 64'(slot_ok[0]), 64'd0);
         chk("dl_no_req", 64'(sdram_req[0]), 64'd0);
         chk("dl_refresh", 64'(refresh_en[0]), 64'd1);
      end
      tick();
      downloading[0] = 1'b0;
      exp_q.push_back(22'h00020);
      exp_q.push_back(22'h00123);
      exp_q.push_back(22'h00200);
      exp_q.push_back(22'h00300);
      serve(0, 1, 1, 32'hA000_0000, 0, 0, '0);
      serve(0, 1, 1, 32'hA000_0001, 0, 0, '0);
      serve(0, 1, 1, 32'hA000_0002, 0, 0, '0);
      serve(0, 1, 1, 32'hA000_0003, 0, 0, '0);
      chk("dl_refetch_ok", 64'(slot_ok[0]), 64'hF);
      chk("dl_refetch_dout1", 64'(slot_dout[0][1*DW +: DW]), 64'hA000_0001);

      // ack and data_rdy in the same cycle
      tick();
      slot_addr[0][3*AW +: AW] = 22'h00333;
      exp_q.push_back(22'h00333);
      serve(0, 1, 0, 32'h3333_3333, 0, 0, '0);
      chk("same_ok", 64'(slot_ok[0][3]), 64'd1);
      chk("same_dout", 64'(slot_dout[0][3*DW +: DW]), 64'h3333_3333);

      // slot_req dropped mid-fetch: cache is still filled
      tick();
      slot_addr[0][2*AW +: AW] = 22'h00444;
      exp_q.push_back(22'h00444);
      serve(0, 1, 2, 32'h4444_4444, 1, 2, '0);
      chk("drop_ok_low", 64'(slot_ok[0][2]), 64'd0);
      tick();
      slot_req[0][2] = 1'b1;
      @(negedge clk);
      chk("drop_hit", 64'(slot_ok[0][2]), 64'd1);
      chk("drop_dout", 64'(slot_dout[0][2*DW +: DW]), 64'h4444_4444);
      chk("drop_no_req", 64'(sdram_req[0]), 64'd0);

      // loop_rst acts as a reset on the next edge
      tick();
      loop_rst[0] = 1'b1;
      @(negedge clk);
      chk("lr_before", 64'(slot_ok[0]), 64'hF);
      tick();
      loop_rst[0] = 1'b0;
      slot_req[0] = 4'b0100;
      @(negedge clk);
      chk("lr_ok_clear", 64'(slot_ok[0]), 64'd0);
      chk("lr_dout_clear", 64'(slot_dout[0][2*DW +: DW]), 64'd0);
      chk("lr_no_req", 64'(sdram_req[0]), 64'd0);
      exp_q.push_back(22'h00444);
      serve(0, 1, 1, 32'h4545_4545, 0, 0, '0);
      chk("lr_refetch_ok", 64'(slot_ok[0][2]), 64'd1);

      // data_rdy in IDLE is ignored
      tick();
      data_rdy[0]  = 1'b1;
      data_read[0] = 32'hBAD0_BAD0;
      tick();
      data_rdy[0]  = 1'b0;
      @(negedge clk);
      chk("idle_rdy_dout", 64'(slot_dout[0][2*DW +: DW]), 64'h4545_4545);
      chk("idle_rdy_ok", 64'(slot_ok[0][2]), 64'd1);
      chk("idle_rdy_req", 64'(sdram_req[0]), 64'd0);

      // reset while instance 0 waits for data and instance 1 waits for ack
      tick();
      slot_req[0] = '0;
      set_slot(0, 1, 22'h00555);
      slot_req[1] = '0;
      set_slot(1, 0, 22'h000B0);
      exp_q.push_back(22'h00555);
      serve(0, 1, -1, '0, 0, 0, '0);
      chk("rr_busy_req", 64'(sdram_req[1]), 64'd1);
      chk("rr_busy_addr", 64'(sdram_addr[1]), 64'h000B0);
      #2;
      rst_n = 1'b0;
      slot_req[0] = '0;
      slot_req[1] = '0;
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("mrst_req", 64'(sdram_req[u]), 64'd0);
         chk("mrst_addr", 64'(sdram_addr[u]), 64'd0);
         chk("mrst_refresh", 64'(refresh_en[u]), 64'd1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      data_rdy[0]  = 1'b1;
      data_read[0] = 32'hFEED_F00D;
      tick();
      data_rdy[0]  = 1'b0;
      tick();
      set_slot(0, 0, 22'h00000);
      set_slot(0, 1, 22'h00555);
      set_slot(0, 2, 22'h00444);
      set_slot(0, 3, 22'h00333);
      #1;
      chk("late_rdy_ok", 64'(slot_ok[0]), 64'd0);
      chk("late_rdy_dout", 64'(slot_dout[0] != '0), 64'd0);
      #1;
      slot_req[0] = '0;
      tick();
      @(negedge clk);
      chk("late_rdy_no_req", 64'(sdram_req[0]), 64'd0);

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
